// File: rtl/bfly_r2_pipe_pkg.sv
// Shared definitions for the radix-2 butterfly: mode encodings plus the
// rounding, halving and saturation helpers used on the wide accumulator.
package bfly_r2_pipe_pkg;

  typedef enum logic {
    BF_DIT = 1'b0,
    BF_DIF = 1'b1
  } bf_mode_e;

  // Wide enough for any DW+TW+2 intermediate when DW,TW <= 22.
  localparam int ACC_W = 48;
  typedef logic signed [ACC_W-1:0] acc_t;

  function automatic acc_t round_shift(input acc_t v, input int frac);
    acc_t half;
    half = acc_t'(1) <<< (frac - 1);
    return (v + half) >>> frac;
  endfunction

  function automatic acc_t half_up(input acc_t v);
    return (v + acc_t'(1)) >>> 1;
  endfunction

  function automatic acc_t sat_hi(input int dw);
    return (acc_t'(1) <<< (dw - 1)) - acc_t'(1);
  endfunction

  // The negative limit is ~hi, i.e. -2^(dw-1).
  function automatic logic is_sat(input acc_t v, input int dw);
    acc_t hi;
    hi = sat_hi(dw);
    return (v > hi) || (v < ~hi);
  endfunction

  function automatic acc_t saturate(input acc_t v, input int dw);
    acc_t hi;
    hi = sat_hi(dw);
    if (v > hi) return hi;
    if (v < ~hi) return ~hi;
    return v;
  endfunction

endpackage

// File: rtl/bfly_r2_pipe_cmul.sv
// Complex multiplier: registers the four partial products (stage 2) and
// presents the combined, rounded product for the stage-3 register.
module cmul_pipe
  import bfly_r2_pipe_pkg::*;
#(
  parameter int PW    = 17,
  parameter int TW    = 16,
  parameter int TFRAC = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic signed [PW-1:0] p_re_i,
  input  logic signed [PW-1:0] p_im_i,
  input  logic signed [TW-1:0] w_re_i,
  input  logic signed [TW-1:0] w_im_i,
  output acc_t                 re_o,
  output acc_t                 im_o
);

  localparam int MW = PW + TW;

  logic signed [MW-1:0] rr_q, ii_q, ri_q, ir_q;
  logic signed [MW-1:0] rr_d, ii_d, ri_d, ir_d;

  always_comb begin
    rr_d = MW'(p_re_i) * MW'(w_re_i);
    ii_d = MW'(p_im_i) * MW'(w_im_i);
    ri_d = MW'(p_re_i) * MW'(w_im_i);
    ir_d = MW'(p_im_i) * MW'(w_re_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
      ii_q <= '0;
      ri_q <= '0;
      ir_q <= '0;
    end else if (en_i) begin
      rr_q <= rr_d;
      ii_q <= ii_d;
      ri_q <= ri_d;
      ir_q <= ir_d;
    end
  end

  assign re_o = round_shift(acc_t'(rr_q) - acc_t'(ii_q), TFRAC);
  assign im_o = round_shift(acc_t'(ri_q) + acc_t'(ir_q), TFRAC);

endmodule

// File: rtl/bfly_r2_pipe.sv
// Three-stage radix-2 butterfly (DIT or DIF per sample) with a global
// stall: every stage holds while the output is valid and not accepted.
module bfly_r2_pipe
  import bfly_r2_pipe_pkg::*;
#(
  parameter int DW    = 16,
  parameter int TW    = 16,
  parameter int TFRAC = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic                 scale,
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [TW-1:0] w_re,
  input  logic signed [TW-1:0] w_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] x_re,
  output logic signed [DW-1:0] x_im,
  output logic signed [DW-1:0] y_re,
  output logic signed [DW-1:0] y_im,
  output logic                 ovf,
  output logic                 ovf_sticky,
  input  logic                 ovf_clr
);

  localparam int PW = DW + 1;

  // Handshake: a sample transfers on in_valid & in_ready, a result on
  // out_valid & out_ready; in_ready is simply "the pipeline is not stalled".
  logic stall, adv;
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  // Stage 1: base operand (A or A+B) and multiplier operand (B or A-B).
  logic                 v1_q, scale1_q;
  bf_mode_e             mode1_q;
  logic signed [PW-1:0] xb_re1_q, xb_im1_q, p_re1_q, p_im1_q;
  logic signed [PW-1:0] xb_re1_d, xb_im1_d, p_re1_d, p_im1_d;
  logic signed [TW-1:0] w_re1_q, w_im1_q;

  always_comb begin
    xb_re1_d = PW'(a_re);
    xb_im1_d = PW'(a_im);
    p_re1_d  = PW'(b_re);
    p_im1_d  = PW'(b_im);
    if (bf_mode_e'(mode) == BF_DIF) begin
      xb_re1_d = PW'(a_re) + PW'(b_re);
      xb_im1_d = PW'(a_im) + PW'(b_im);
      p_re1_d  = PW'(a_re) - PW'(b_re);
      p_im1_d  = PW'(a_im) - PW'(b_im);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      mode1_q  <= BF_DIT;
      scale1_q <= 1'b0;
      xb_re1_q <= '0;
      xb_im1_q <= '0;
      p_re1_q  <= '0;
      p_im1_q  <= '0;
      w_re1_q  <= '0;
      w_im1_q  <= '0;
    end else if (adv) begin
      v1_q     <= in_valid;
      mode1_q  <= bf_mode_e'(mode);
      scale1_q <= scale;
      xb_re1_q <= xb_re1_d;
      xb_im1_q <= xb_im1_d;
      p_re1_q  <= p_re1_d;
      p_im1_q  <= p_im1_d;
      w_re1_q  <= w_re;
      w_im1_q  <= w_im;
    end
  end

  // Stage 2: products live in the multiplier; side data travels alongside.
  logic                 v2_q, scale2_q;
  bf_mode_e             mode2_q;
  logic signed [PW-1:0] xb_re2_q, xb_im2_q;
  acc_t                 prod_re, prod_im;

  cmul_pipe #(.PW(PW), .TW(TW), .TFRAC(TFRAC)) u_cmul (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (adv),
    .p_re_i (p_re1_q),
    .p_im_i (p_im1_q),
    .w_re_i (w_re1_q),
    .w_im_i (w_im1_q),
    .re_o   (prod_re),
    .im_o   (prod_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q     <= 1'b0;
      mode2_q  <= BF_DIT;
      scale2_q <= 1'b0;
      xb_re2_q <= '0;
      xb_im2_q <= '0;
    end else if (adv) begin
      v2_q     <= v1_q;
      mode2_q  <= mode1_q;
      scale2_q <= scale1_q;
      xb_re2_q <= xb_re1_q;
      xb_im2_q <= xb_im1_q;
    end
  end

  // Stage 3: combine at full width, optional halving, then saturate.
  acc_t                 pre [4];
  logic signed [DW-1:0] res_d [4];
  logic signed [DW-1:0] res_q [4];
  acc_t                 sat_v;
  logic                 any_sat, ovf_d, out_valid_q, ovf_q, ovf_sticky_q, ovf_sticky_d;

  always_comb begin
    pre[0] = acc_t'(xb_re2_q);
    pre[1] = acc_t'(xb_im2_q);
    pre[2] = prod_re;
    pre[3] = prod_im;
    if (mode2_q == BF_DIT) begin
      pre[0] = acc_t'(xb_re2_q) + prod_re;
      pre[1] = acc_t'(xb_im2_q) + prod_im;
      pre[2] = acc_t'(xb_re2_q) - prod_re;
      pre[3] = acc_t'(xb_im2_q) - prod_im;
    end
    any_sat = 1'b0;
    sat_v   = '0;
    for (int k = 0; k < 4; k++) begin
      if (scale2_q) pre[k] = half_up(pre[k]);
      any_sat  = any_sat | is_sat(pre[k], DW);
      sat_v    = saturate(pre[k], DW);
      res_d[k] = sat_v[DW-1:0];
    end
    ovf_d        = v2_q & any_sat;
    ovf_sticky_d = (ovf_sticky_q & ~ovf_clr) | (adv & ovf_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      ovf_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
      for (int k = 0; k < 4; k++) res_q[k] <= '0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
      if (adv) begin
        out_valid_q <= v2_q;
        ovf_q       <= ovf_d;
        for (int k = 0; k < 4; k++) res_q[k] <= res_d[k];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = ovf_sticky_q;
  assign x_re       = res_q[0];
  assign x_im       = res_q[1];
  assign y_re       = res_q[2];
  assign y_im       = res_q[3];

endmodule

// File: tb/tb_bfly_r2_pipe.sv
// Bench for bfly_r2_pipe: arithmetic reference model feeding an expected
// queue, directed vectors with literal results, stall and reset scenarios.
module tb_bfly_r2_pipe;

  localparam int DW = 16;
  localparam int W  = 4 * DW + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0, in_ready;
  logic                 mode = 1'b0, scale = 1'b0;
  logic signed [15:0]   a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;
  logic                 out_valid, out_ready = 1'b1;
  logic signed [15:0]   x_re, x_im, y_re, y_im;
  logic                 ovf, ovf_sticky, ovf_clr = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int pop_cnt  = 0;
  bit saw_in_ready_low = 0;
  logic [W-1:0] exp_q[$];

  bfly_r2_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .scale(scale), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_re(w_re), .w_im(w_im), .out_valid(out_valid), .out_ready(out_ready),
    .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im),
    .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic longint rnd(input longint v);
    return (v + 64'sd8192) >>> 14;
  endfunction

  // Butterfly result straight from the arithmetic definition.
  function automatic logic [W-1:0] model(input bit md, input bit sc,
                                         input longint ar, input longint ai,
                                         input longint br, input longint bi,
                                         input longint wr, input longint wi);
    longint r[4];
    longint dr, di;
    bit o;
    if (!md) begin
      dr = rnd(br * wr - bi * wi);
      di = rnd(br * wi + bi * wr);
      r[0] = ar + dr; r[1] = ai + di; r[2] = ar - dr; r[3] = ai - di;
    end else begin
      dr = ar - br; di = ai - bi;
      r[0] = ar + br; r[1] = ai + bi;
      r[2] = rnd(dr * wr - di * wi);
      r[3] = rnd(dr * wi + di * wr);
    end
    o = 0;
    for (int k = 0; k < 4; k++) begin
      if (sc) r[k] = (r[k] + 1) >>> 1;
      if (r[k] > 32767) begin r[k] = 32767; o = 1; end
      if (r[k] < -32768) begin r[k] = -32768; o = 1; end
    end
    return {r[0][15:0], r[1][15:0], r[2][15:0], r[3][15:0], o};
  endfunction

  function automatic logic [W-1:0] cur_out();
    return {x_re, x_im, y_re, y_im, ovf};
  endfunction

  // ---------------- scoreboard: push on accept, compare on transfer ----------------
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready)
      exp_q.push_back(model(mode, scale, longint'(a_re), longint'(a_im), longint'(b_re),
                            longint'(b_im), longint'(w_re), longint'(w_im)));
  end

  logic [W-1:0] prev_out;
  bit prev_stall = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) chk("stall_stable", cur_out(), prev_out);
      if (out_valid && !out_ready) begin
        if (!in_ready) saw_in_ready_low = 1;
        chk("in_ready_in_stall", W'(in_ready), W'(0));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", cur_out(), '1);
        else begin
          chk("result", cur_out(), exp_q.pop_front());
          pop_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = cur_out();
    end
  end

  // ---------------- driver tasks (start/end at posedge+1) ----------------
  task automatic drive(input bit md, input bit sc, input int ar, input int ai,
                       input int br, input int bi, input int wr, input int wi);
    bit ok;
    mode = md; scale = sc;
    a_re = 16'(ar); a_im = 16'(ai); b_re = 16'(br); b_im = 16'(bi);
    w_re = 16'(wr); w_im = 16'(wi);
    in_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", W'(0), W'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_lit(input string name, input int xr, input int xi, input int yr,
                            input int yi, input bit ov, input int stk);
    bit seen;
    logic [W-1:0] e;
    e = {16'(xr), 16'(xi), 16'(yr), 16'(yi), ov};
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
    end
    chk({name, "_valid"}, W'(seen), W'(1));
    if (seen) begin
      chk(name, cur_out(), e);
      if (stk >= 0) chk({name, "_sticky"}, W'(ovf_sticky), W'(stk));
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, {x_re, x_im, y_re, y_im, ovf}, '0);
    chk({name, "_flags"}, W'({out_valid, ovf_sticky}), W'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1;
    check_reset_outputs("reset_state");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("in_ready_after_reset", W'(in_ready), W'(1));

    drive(0, 0, 1000, 0, 200, 0, 16384, 0);
    expect_lit("dit_real", 1200, 0, 800, 0, 0, 0);
    drive(0, 0, 0, 0, 100, 50, 0, -16384);
    expect_lit("dit_minus_j", 50, -100, -50, 100, 0, -1);
    drive(0, 0, 32767, 0, 32767, 0, 16384, 0);
    expect_lit("dit_sat", 32767, 0, 0, 0, 1, 1);

    ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    chk("sticky_cleared", W'(ovf_sticky), W'(0));

    drive(0, 1, 32767, 0, 32767, 0, 16384, 0);
    expect_lit("dit_scaled", 32767, 0, 0, 0, 0, 0);

    ovf_clr = 1'b1;
    drive(0, 0, 32767, 0, 32767, 0, 16384, 0);
    expect_lit("clr_with_new_ovf", 32767, 0, 0, 0, 1, 1);
    ovf_clr = 1'b0;
    chk("sticky_clr_after", W'(ovf_sticky), W'(0));

    drive(1, 0, 300, 0, 100, 0, 0, 16384);
    expect_lit("dif_j", 400, 0, 0, 200, 0, -1);

    // Eight back-to-back samples with a four-cycle downstream stall.
    pop_cnt = 0;
    fork
      for (int i = 0; i < 8; i++) begin
        if (i == 7) drive(0, 0, 32000, -32000, 32000, -32000, 16384, 0);
        else drive((i % 2) == 1, i == 5, 1000 * i - 3000, 250 * i, -700 + 300 * i,
                   400 - 90 * i, ((i % 2) == 1) ? 11585 : 16000 - 1500 * i,
                   -11585 + 3000 * i);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk("stream_drained", W'(exp_q.size()), W'(0));
    chk("stream_count", W'(pop_cnt), W'(8));
    chk("stream_in_ready_dropped", W'(saw_in_ready_low), W'(1));

    // Reset with three samples in flight (first one overflows).
    drive(0, 0, 32767, 0, 32767, 0, 16384, 0);
    drive(0, 0, 100, 0, 10, 0, 16384, 0);
    drive(1, 0, 50, 50, 20, 20, 16384, 0);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset_in_flight");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("in_ready_after_rerelease", W'(in_ready), W'(1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_stale_valid", W'(out_valid), W'(0));
    end
    @(posedge clk); #1;
    mode = 1'b0; scale = 1'b0;
    a_re = 5; a_im = 6; b_re = 7; b_im = 8; w_re = 16384; w_im = 0;
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    chk("latency_edge1", W'(out_valid), W'(0));
    @(posedge clk); #1;
    chk("latency_edge2", W'(out_valid), W'(0));
    @(posedge clk); #1;
    chk("latency_edge3", W'(out_valid), W'(1));
    chk("latency_value", cur_out(), {16'sd12, 16'sd14, -16'sd2, -16'sd2, 1'b0});
    repeat (3) @(posedge clk);
    #1 chk("final_queue_empty", W'(exp_q.size()), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bfly_r2_pipe.md
BFLY_R2_PIPE -- requirements
Module: bfly_r2_pipe

Interface
REQ-001 Parameter DW, 16, signed data width of the A/B inputs and X/Y outputs.
REQ-002 Parameter TW, 16, signed twiddle width.
REQ-003 Parameter TFRAC, 14, twiddle fraction bits (1.0 = 2^TFRAC).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  input sample present.
REQ-007 in_ready  out  1  block accepts the sample this cycle.
REQ-008 mode  in  1  0 = DIT, 1 = DIF; sampled with data.
REQ-009 scale  in  1  1 = divide both outputs by 2; sampled with data.
REQ-010 a_re, a_im, b_re, b_im  in  DW each  signed operands.
REQ-011 w_re, w_im  in  TW each  signed twiddle.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 x_re, x_im, y_re, y_im  out  DW each  signed results.
REQ-015 ovf  out  1  saturation occurred in this result.
REQ-016 ovf_sticky  out  1  OR of all ovf since reset or clear.
REQ-017 ovf_clr  in  1  synchronous clear of ovf_sticky.

Function
REQ-018 DIT: X = A + B*W, Y = A - B*W; DIF: X = A + B, Y = (A - B)*W.
REQ-019 The complex product SHALL be computed at full precision: re = Pr*Wr - Pi*Wi, im = Pr*Wi + Pi*Wr, at width DW+TW+1.
REQ-020 The product SHALL be rounded half-up: add 2^(TFRAC-1), then arithmetic shift right by TFRAC.
REQ-021 Additions SHALL use one guard bit. There is no intermediate truncation.
REQ-022 If scale = 1, each pre-saturation result SHALL be (v + 1) >>> 1.
REQ-023 Each of the four results SHALL saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-024 ovf SHALL be 1 if any of the four results saturated.
REQ-025 The pipeline SHALL have three register stages, giving a latency of 3 accepted cycles for both modes:
- S1: register inputs; A±B in DIF.
- S2: four products.
- S3: combine, round, scale, saturate.
REQ-026 mode and scale SHALL travel with their sample, so mixed-mode streams stay correct.
REQ-027 Define stall = out_valid & ~out_ready. When stall = 1, all stages SHALL hold and in_ready = 0.
REQ-028 When stall = 0, the stages SHALL advance and in_ready = 1.
REQ-029 A transfer SHALL occur only when in_valid & in_ready. Bubbles SHALL propagate as stage valid = 0.
REQ-030 Outputs SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-031 ovf_sticky SHALL set on any transferred result with ovf = 1. If ovf_clr and a new ovf occur in the same cycle, ovf_sticky SHALL be 1.

Reset
REQ-032 On rst_n low, all stage valids, out_valid, ovf and ovf_sticky SHALL be 0, and x/y SHALL be 0, immediately.
REQ-033 In-flight samples SHALL be discarded on reset.
REQ-034 in_ready SHALL be 1 on the first cycle after release.

Structure
REQ-035 A shared package SHALL hold the mode encodings (BF_DIT, BF_DIF) and the rounding and saturation helper functions.
REQ-036 One sub-module, cmul_pipe, SHALL hold the complex multiply and rounding stages (S2 and S3 product path) with an enable input.

Verification
REQ-037 DIT, W = (16384, 0), A = (1000, 0), B = (200, 0), scale = 0 -> three cycles later X = (1200, 0), Y = (800, 0), ovf = 0.
REQ-038 DIT, W = (0, -16384), A = (0, 0), B = (100, 50) -> X = (50, -100), Y = (-50, 100).
REQ-039 DIT, W = (16384, 0), A = B = (32767, 0):
- scale = 0 -> X = (32767, 0), Y = (0, 0), ovf = 1, ovf_sticky = 1.
- scale = 1 -> X = (32767, 0), ovf = 0.
REQ-040 DIF, W = (0, 16384), A = (300, 0), B = (100, 0) -> X = (400, 0), Y = (0, 200).
REQ-041 Stream 8 samples with in_valid held high and out_ready low for 4 cycles mid-stream -> in_ready drops, all 8 results appear in order with no loss or duplication, and outputs are stable during the stall.
REQ-042 Assert rst_n low with 3 samples in flight -> outputs zero immediately, no stale out_valid after release, and the first new sample appears three cycles after acceptance.
